// File: rtl/pwm_preconditioner.sv
// pwm_preconditioner
// ------------------
// Takes one burst of per-transducer (pulse width, phase) beats per frame from
// the pulse-width encoder. It converts each beat into rise/fall edge times on
// a 512-tick carrier and stores the result in a double-buffered table. The
// active bank is swapped only on an UPDATE strobe while a complete frame is
// pending. The PWM timers read the active bank through an indexed port with a
// latency of one cycle.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   DIN_VALID       beat valid; a frame is DEPTH consecutive high cycles
//   PULSE_WIDTH_IN  pulse width in ticks (0..511)
//   PHASE_IN        phase, 1 LSB = 2 ticks
//   UPDATE          carrier-boundary strobe requesting a bank swap
//   RD_IDX          transducer index for the read port
//   RISE_OUT        registered rise tick of RD_IDX in the active bank
//   FALL_OUT        registered fall tick of RD_IDX in the active bank
//   BANK            currently active bank
//   FRAME_DONE      1-cycle pulse: a complete frame was captured
//   FRAME_ERR       1-cycle pulse: a frame was truncated and discarded
//   FRAME_CNT       (PWM_PRECONDITIONER_STATS_EN only) saturating count of FRAME_DONE
//   ERR_CNT         (PWM_PRECONDITIONER_STATS_EN only) saturating count of FRAME_ERR
//   STATE_DBG       current FSM state, for debug visibility
//
// Handshake: the beat interface has no back-pressure. A beat is accepted on
// every rising edge where DIN_VALID is high. The DEPTH beats of a frame must
// arrive on consecutive cycles; a low DIN_VALID mid-frame truncates it.
//
// Optional feature macro: PWM_PRECONDITIONER_STATS_EN adds FRAME_CNT/ERR_CNT.
module pwm_preconditioner #(
  parameter int DEPTH = 249
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DIN_VALID,
  input  logic [8:0]  PULSE_WIDTH_IN,
  input  logic [7:0]  PHASE_IN,
  input  logic        UPDATE,
  input  logic [7:0]  RD_IDX,
  output logic [8:0]  RISE_OUT,
  output logic [8:0]  FALL_OUT,
  output logic        BANK,
  output logic        FRAME_DONE,
  output logic        FRAME_ERR,
`ifdef PWM_PRECONDITIONER_STATS_EN
  output logic [15:0] FRAME_CNT,
  output logic [15:0] ERR_CNT,
`endif
  output logic [1:0]  STATE_DBG
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam logic [8:0]    DEPTH9 = 9'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          bank_q, bank_d;
  logic [1:0]    loaded_q, loaded_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [8:0]    rise_q, fall_q;

  // Write-port controls derived by the FSM.
  logic          we;
  logic          wr_bank;
  logic [AW-1:0] wr_idx;

  // Table storage: {rise, fall} per transducer per bank. Not reset.
  logic [17:0] mem_q [2][DEPTH];

  // ---------------------------------------------------------------------------
  // Edge computation (combinational, modulo 512).
  // fall uses a 10-bit sum so that pw=511 rounds up to 256 instead of wrapping.
  // ---------------------------------------------------------------------------
  logic [8:0] center;
  logic [9:0] half_up;
  logic [8:0] rise_calc, fall_calc;

  always_comb begin
    center    = {PHASE_IN, 1'b0};
    half_up   = ({1'b0, PULSE_WIDTH_IN} + 10'd1) >> 1;
    rise_calc = center - {1'b0, PULSE_WIDTH_IN[8:1]};
    fall_calc = center + half_up[8:0];
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, bank control, write port and status pulses.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    we       = 1'b0;
    wr_bank  = ~bank_q;
    wr_idx   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (DIN_VALID) begin
          we      = 1'b1;
          wr_idx  = '0;
          cnt_d   = AW'(1);
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (DIN_VALID) begin
          we     = 1'b1;
          wr_idx = cnt_q;
          if (cnt_q == LAST) begin
            cnt_d              = '0;
            done_d             = 1'b1;
            loaded_d[~bank_q]  = 1'b1;
            state_d            = PENDING;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end else begin
          // Truncated frame: the shadow bank must never become active.
          cnt_d             = '0;
          err_d             = 1'b1;
          loaded_d[~bank_q] = 1'b0;
          state_d           = IDLE;
        end
      end

      PENDING: begin
        if (UPDATE && DIN_VALID) begin
          // Swap first; the beat lands in the bank that was active until now,
          // which becomes the new shadow.
          bank_d           = ~bank_q;
          loaded_d[bank_q] = 1'b0;
          we               = 1'b1;
          wr_bank          = bank_q;
          wr_idx           = '0;
          cnt_d            = AW'(1);
          state_d          = LOAD;
        end else if (UPDATE) begin
          bank_d  = ~bank_q;
          state_d = IDLE;
        end else if (DIN_VALID) begin
          // Latest frame wins: the pending frame is overwritten in place.
          loaded_d[~bank_q] = 1'b0;
          we                = 1'b1;
          wr_idx            = '0;
          cnt_d             = AW'(1);
          state_d           = LOAD;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bank_q   <= 1'b0;
      loaded_q <= 2'b00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bank_q   <= bank_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[wr_bank][wr_idx] <= {rise_calc, fall_calc};
    end
  end

  // ---------------------------------------------------------------------------
  // Read port. Uses the pre-edge bank, so a read in the swap cycle still
  // returns the old bank. Out-of-range indices and unloaded banks read 0/0.
  // ---------------------------------------------------------------------------
  logic          rd_ok;
  logic [AW-1:0] rd_addr;

  always_comb begin
    rd_ok   = ({1'b0, RD_IDX} < DEPTH9) && loaded_q[bank_q];
    rd_addr = rd_ok ? AW'(RD_IDX) : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rise_q <= '0;
      fall_q <= '0;
    end else if (rd_ok) begin
      {rise_q, fall_q} <= mem_q[bank_q][rd_addr];
    end else begin
      rise_q <= '0;
      fall_q <= '0;
    end
  end

`ifdef PWM_PRECONDITIONER_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (done_d && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_d && (err_cnt_q != 16'hFFFF))    err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign FRAME_CNT = frame_cnt_q;
  assign ERR_CNT   = err_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

  assign RISE_OUT   = rise_q;
  assign FALL_OUT   = fall_q;
  assign BANK       = bank_q;
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = err_q;
  assign STATE_DBG  = state_q;

endmodule

// File: doc/pwm_preconditioner.md
Name: pwm_preconditioner

Overview:
- Sits directly downstream of the pulse-width encoder.
- Accepts one burst of per-transducer (pulse width, phase) beats per frame and converts each beat into rise/fall edge times on a 512-tick carrier period.
- Stores the results in a double-buffered table and swaps banks only on an UPDATE strobe when a complete frame is pending.
- The per-transducer PWM timers read the active bank through an indexed port.

Parameters:
- DEPTH, 249, number of transducers (beats per frame); must be 2..256.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; one clock; asynchronous, active-low.
- DIN_VALID  in  1  beat valid; a frame is DEPTH consecutive high cycles.
- PULSE_WIDTH_IN  in  9  pulse width in ticks, 0..511.
- PHASE_IN  in  8  phase; 1 LSB = 2 ticks.
- UPDATE  in  1  single-cycle carrier-boundary strobe; requests a bank swap.
- RD_IDX  in  8  transducer index for the read port.
- RISE_OUT  out  9  rise tick of RD_IDX in the active bank.
- FALL_OUT  out  9  fall tick of RD_IDX in the active bank.
- BANK  out  1  currently active bank.
- FRAME_DONE  out  1  1-cycle pulse: a complete frame was captured.
- FRAME_ERR  out  1  1-cycle pulse: a frame was truncated and discarded.

Behaviour:
- Reset (async assert, sync release): state IDLE, cnt=0, BANK=0, bank_loaded[1:0]=0. RISE_OUT, FALL_OUT, FRAME_DONE and FRAME_ERR are all 0. RAM contents are not reset.
- Arithmetic, all modulo 512, 9-bit:
  - c = {PHASE_IN,1'b0}.
  - rise = c - (pw>>1).
  - fall = c + ((pw+1)>>1).
  - pw=0 gives rise==fall, which downstream treats as "never high".
  - The computation is combinational. The result is written to the shadow bank (~BANK) at index cnt on the same edge the beat is accepted.
- State IDLE:
  - DIN_VALID=1: write index 0, cnt<=1, go to LOAD.
  - UPDATE is ignored.
- State LOAD:
  - DIN_VALID=1: write index cnt, cnt<=cnt+1.
  - When index DEPTH-1 is written: go to PENDING, FRAME_DONE=1 next cycle, set bank_loaded[~BANK].
  - DIN_VALID=0 before DEPTH beats: FRAME_ERR=1 next cycle, clear bank_loaded[~BANK], go to IDLE. The partial frame is never made active.
  - UPDATE is ignored, including in the cycle the last beat is written.
- State PENDING:
  - UPDATE=1, DIN_VALID=0: BANK<=~BANK, go to IDLE.
  - DIN_VALID=1, UPDATE=0: the new frame overwrites the shadow bank. Clear bank_loaded[~BANK], write index 0, cnt<=1, go to LOAD. The latest frame wins and the pending frame is dropped.
  - UPDATE=1 and DIN_VALID=1 together: swap first (BANK<=~BANK). The beat is written to index 0 of the new shadow bank (the old active bank), whose bank_loaded is cleared; cnt<=1, go to LOAD.
- Read port, latency 1:
  - RISE_OUT/FALL_OUT are registered from bank BANK at RD_IDX.
  - Output 0/0 if RD_IDX>=DEPTH or bank_loaded[BANK]=0.
  - A read in the swap cycle returns the pre-swap bank. The new bank is visible from the next edge.
- FRAME_DONE and FRAME_ERR are mutually exclusive.
- Reset mid-LOAD or mid-PENDING discards everything. After reset, reads return 0 until the first swap of a complete frame.

Optional Feature:
- Macro: PWM_PRECONDITIONER_STATS_EN.
- Defined: adds outputs FRAME_CNT[15:0] and ERR_CNT[15:0].
  - FRAME_CNT increments on each FRAME_DONE; ERR_CNT increments on each FRAME_ERR.
  - Both saturate at 0xFFFF and are reset to 0 by RST_N.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan (DEPTH=4):
- 4 beats pw=100, phase=10 -> FRAME_DONE high 1 cycle after beat 3. Then UPDATE -> BANK 0->1. Then RD_IDX=2 -> next cycle RISE_OUT=482, FALL_OUT=70.
- Beats pw=0, phase=0x80 and pw=511, phase=0, then UPDATE -> idx0 reads 256/256; idx1 reads 257/256.
- 2 beats, then DIN_VALID low, then UPDATE -> FRAME_ERR 1 cycle, no FRAME_DONE, BANK unchanged, reads still return the old bank (0/0 if none loaded).
- Full frame A pending, then UPDATE coincident with the first beat of frame B -> BANK toggles and frame A is readable. After frame B completes and the next UPDATE, frame B is readable.
- Frame pending, then second full frame without UPDATE, then UPDATE -> the second frame's values are active. Nothing from the first frame is visible at any time.
- RST_N low mid-LOAD -> all outputs 0, BANK=0. After release, reads return 0/0 until a completed frame is swapped in. With STATS_EN, counters read 0.
